pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/pc_target_calc.sv | 18 +
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end.
//   ADDR_W               : fetch address width
//   DEFAULT_RESET_VECTOR : default first fetch address after reset
//   state_t              : fetch FSM states
//   redir_t              : redirect kinds; encoding doubles as priority (higher wins)
//   redir_req_t          : redirect kind plus its resolved byte target
package cpu_pkg;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2,
        RD_JR     = 2'd3
    } redir_t;

    typedef struct packed {
        redir_t              kind;
        logic [ADDR_W-1:0]   target;
    } redir_req_t;
endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch / jump target arithmetic.
//   pc_plus4      in  : address of the next sequential instruction
//   branch_imm    in  : sign-extended word offset
//   jump_index    in  : J-type word index
//   branch_target out : pc_plus4 + (branch_imm << 2), wraps modulo 2^32
//   jump_target   out : {pc_plus4[31:28], jump_index, 2'b00}
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] branch_imm,
    input  logic [25:0]       jump_index,
    output logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] jump_target
);
    assign branch_target = pc_plus4 + (branch_imm << 2);
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction-fetch sequencer.
//   clk, rst_n        : clock, async active-low reset
//   stall             : downstream hold, freezes pc after a completed fetch
//   branch_taken/imm  : PC-relative redirect
//   jump/jump_index   : J-type redirect
//   jr/jr_target      : register redirect (must be word aligned)
//   imem_ready        : instruction memory accepts/returns the current request
//   imem_req, pc      : fetch request and its address
//   pc_plus4          : pc + 4
//   fetch_done        : pulse on the cycle a fetch completes
//   align_err         : sticky, set by a misaligned jr target; parks the FSM in ERROR
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_done,
    output logic              align_err
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    redir_req_t        r_pend;
    logic              r_align_err;

    logic [ADDR_W-1:0] w_pc_plus4, w_branch_target, w_jump_target, w_next_pc;
    redir_req_t        w_cur, w_sel;
    logic              w_complete, w_advance, w_misalign;

    assign w_pc_plus4 = r_pc + 32'd4;

    pc_target_calc u_calc (
        .pc_plus4      (w_pc_plus4),
        .branch_imm    (branch_imm),
        .jump_index    (jump_index),
        .branch_target (w_branch_target),
        .jump_target   (w_jump_target)
    );

    // Highest-priority redirect presented this cycle.
    always_comb begin
        w_cur = '{kind: RD_NONE, target: w_pc_plus4};
        if (jr)                w_cur = '{kind: RD_JR,     target: jr_target};
        else if (jump)         w_cur = '{kind: RD_JUMP,   target: w_jump_target};
        else if (branch_taken) w_cur = '{kind: RD_BRANCH, target: w_branch_target};
    end

    // Merge with the pending latch: a live request of equal or higher
    // priority overrides, a lower one is dropped. pc is constant while a
    // redirect is pending, so latched branch/jump targets stay valid.
    always_comb begin
        w_sel = r_pend;
        if (w_cur.kind != RD_NONE && w_cur.kind >= r_pend.kind) w_sel = w_cur;
    end

    assign w_next_pc  = (w_sel.kind == RD_NONE) ? w_pc_plus4 : w_sel.target;
    assign w_misalign = (w_sel.kind == RD_JR) && (w_sel.target[1:0] != 2'b00);
    assign w_complete = (r_state == ST_FETCH) && imem_ready;
    // pc moves on an unstalled completion, or when stall drops in HOLD.
    assign w_advance  = (w_complete || r_state == ST_HOLD) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VECTOR;
            r_pend      <= '0;
            r_align_err <= 1'b0;
        end else begin
            unique case (r_state)
                ST_BOOT: r_state <= ST_FETCH;
                ST_FETCH, ST_HOLD: begin
                    if (w_advance) begin
                        if (w_misalign) begin
                            r_align_err <= 1'b1;
                            r_state     <= ST_ERROR;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_pend  <= '0;
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        // Carries redirects across a wait for ready and
                        // through HOLD until pc is finally updated.
                        r_pend <= w_sel;
                        if (w_complete) r_state <= ST_HOLD;
                    end
                end
                default: ; // ST_ERROR: frozen until reset
            endcase
        end
    end

    assign imem_req   = (r_state == ST_FETCH);
    assign fetch_done = w_complete;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign align_err  = r_align_err;
endmodule
